// File: rtl/stb_seq_pkg.sv
// Shared types for the strobe-channel sequencer.
//   state_e  : sequencer FSM states
//   status_e : 2-bit completion code reported on status_o
package stb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_DROP,
    WAIT_RDY,
    RUN,
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_ERR_DET = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ABORTED = 2'd3
  } status_e;

endpackage

// File: rtl/stb_seq_timer.sv
// Wait-phase timer for the strobe-channel sequencer.
//   clk_i/arst_i : clock, async active-high reset
//   clr_i        : synchronous clear (wins over en_i)
//   en_i         : count enable; the counter saturates at all-ones
//   timeout_i    : limit in cycles, 0 disables expiry
//   expire_o     : high while cnt == timeout_i-1 (and timeout_i != 0)
module stb_seq_timer #(
  parameter int unsigned TO_WIDTH = 24
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [TO_WIDTH-1:0] timeout_i,
  output logic                expire_o
);

  logic [TO_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TO_WIDTH'(1);
    end
  end

  assign expire_o = (timeout_i != '0) && (cnt_q == (timeout_i - TO_WIDTH'(1)));

endmodule

// File: rtl/stb_seq_ctrl.sv
// Sequencer for one strobe-generator channel.
// Start -> pulse run_det -> wait for rdy to drop and return -> enable the
// strobe output for exactly N strobes -> report done + status.
//   start_i/abort_i   : software control (start only sampled in IDLE)
//   n_stb_i/timeout_i : latched on accepted start
//   rdy_i/err_i/stb_i : generator status and gated strobe
//   run_det_o/oe_o    : generator control
//   busy_o/done_o/status_o/stb_cnt_o : sequence reporting
// All outputs are registered from the next-state decode.
module stb_seq_ctrl
  import stb_seq_pkg::*;
#(
  parameter int unsigned N_WIDTH  = 16,
  parameter int unsigned TO_WIDTH = 24
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [N_WIDTH-1:0]  n_stb_i,
  input  logic [TO_WIDTH-1:0] timeout_i,
  input  logic                rdy_i,
  input  logic                err_i,
  input  logic                stb_i,
  output logic                run_det_o,
  output logic                oe_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [1:0]          status_o,
  output logic [N_WIDTH-1:0]  stb_cnt_o
);

  state_e              state_q, state_d;
  status_e             fin_status;
  status_e             status_q;
  logic [N_WIDTH-1:0]  n_q, cnt_q, cnt_d;
  logic [TO_WIDTH-1:0] to_q;
  logic                stb_q;
  logic                run_det_q, oe_q, busy_q, done_q;
  logic                run_det_d, oe_d, busy_d, done_d;
  logic                start_acc, stb_rise, cnt_hit;
  logic                tmr_clr, tmr_exp;

  assign start_acc = (state_q == IDLE) && start_i;
  assign stb_rise  = (state_q == RUN) && stb_i && !stb_q;
  assign cnt_d     = (stb_rise && (cnt_q != '1)) ? cnt_q + N_WIDTH'(1) : cnt_q;
  assign cnt_hit   = stb_rise && (cnt_d == n_q);

  // Timer restarts at the beginning of every wait phase and after each strobe.
  assign tmr_clr = start_acc || stb_rise ||
                   ((state_d != state_q) && (state_d inside {WAIT_DROP, WAIT_RDY, RUN}));

  stb_seq_timer #(
    .TO_WIDTH (TO_WIDTH)
  ) u_timer (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .clr_i     (tmr_clr),
    .en_i      (state_q != IDLE),
    .timeout_i (to_q),
    .expire_o  (tmr_exp)
  );

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; priority abort > err > timeout > progress
  always_comb begin
    state_d    = state_q;
    fin_status = ST_OK;
    unique case (state_q)
      IDLE: if (start_i) state_d = ARM;
      ARM: begin
        if (abort_i) begin
          state_d = FINISH; fin_status = ST_ABORTED;
        end else begin
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (abort_i) begin
          state_d = FINISH; fin_status = ST_ABORTED;
        end else if (tmr_exp) begin
          state_d = FINISH; fin_status = ST_TIMEOUT;
        end else if (!rdy_i) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (abort_i) begin
          state_d = FINISH; fin_status = ST_ABORTED;
        end else if (rdy_i && err_i) begin
          state_d = FINISH; fin_status = ST_ERR_DET;
        end else if (tmr_exp) begin
          state_d = FINISH; fin_status = ST_TIMEOUT;
        end else if (rdy_i) begin
          state_d = (n_q == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = FINISH; fin_status = ST_ABORTED;
        end else if (err_i) begin
          state_d = FINISH; fin_status = ST_ERR_DET;
        end else if (tmr_exp) begin
          state_d = FINISH; fin_status = ST_TIMEOUT;
        end else if (cnt_hit) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from next state, registered below
  always_comb begin
    run_det_d = (state_d == ARM);
    oe_d      = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FINISH);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      run_det_q <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      n_q       <= '0;
      to_q      <= '0;
      cnt_q     <= '0;
      stb_q     <= 1'b0;
    end else begin
      run_det_q <= run_det_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      stb_q     <= stb_i;
      if (start_acc) begin
        n_q      <= n_stb_i;
        to_q     <= timeout_i;
        cnt_q    <= '0;
        status_q <= ST_OK;
      end else begin
        cnt_q <= cnt_d;
        if (state_d == FINISH) status_q <= fin_status;
      end
    end
  end

  assign run_det_o = run_det_q;
  assign oe_o      = oe_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign status_o  = status_q;
  assign stb_cnt_o = cnt_q;

endmodule

// File: tb/tb_stb_seq_ctrl.sv
// Self-checking bench for stb_seq_ctrl with a behavioural strobe-generator
// model and a scoreboard of expected {status, count} per completed sequence.
module tb_stb_seq_ctrl;

  localparam int NW = 16;
  localparam int TW = 24;

  logic          clk_i = 1'b0;
  logic          arst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [NW-1:0] n_stb_i = '0;
  logic [TW-1:0] timeout_i = '0;
  logic          rdy_i = 1'b1;
  logic          err_i = 1'b0;
  logic          stb_i = 1'b0;
  logic          run_det_o, oe_o, busy_o, done_o;
  logic [1:0]    status_o;
  logic [NW-1:0] stb_cnt_o;

  always #5 clk_i = ~clk_i;

  stb_seq_ctrl #(
    .N_WIDTH  (NW),
    .TO_WIDTH (TW)
  ) dut (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .n_stb_i   (n_stb_i),
    .timeout_i (timeout_i),
    .rdy_i     (rdy_i),
    .err_i     (err_i),
    .stb_i     (stb_i),
    .run_det_o (run_det_o),
    .oe_o      (oe_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .status_o  (status_o),
    .stb_cnt_o (stb_cnt_o)
  );

  typedef struct {
    logic [1:0]    status;
    logic [NW-1:0] cnt;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Generator model configuration (written by tests, read by model)
  int g_low = 40;
  int g_period = 20;
  bit g_err = 1'b0;
  bit g_hold = 1'b0;
  // Generator model state
  int g_t = 0;
  int g_s = 0;
  bit g_active = 1'b0;

  // rdy drops one cycle after run_det, returns g_low cycles later (optionally
  // with err); while oe is high a one-cycle strobe appears every g_period.
  always @(negedge clk_i) begin
    if (run_det_o) begin
      g_active = 1'b1; g_t = 0;
    end else if (!busy_o) begin
      g_active = 1'b0;
    end else if (g_active) begin
      g_t++;
    end
    if (!g_active) begin
      rdy_i = 1'b1; err_i = 1'b0;
    end else if (!g_hold) begin
      if (g_t == 1) rdy_i = 1'b0;
      else if (g_t == 1 + g_low) begin rdy_i = 1'b1; err_i = g_err; end
    end
    if (oe_o) begin
      g_s++; stb_i = ((g_s % g_period) == 0);
    end else begin
      g_s = 0; stb_i = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic do_start(input logic [NW-1:0] n, input logic [TW-1:0] to);
    n_stb_i = n; timeout_i = to; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output bit seen, output bit oe_seen);
    cyc = 0; seen = 1'b0; oe_seen = 1'b0;
    while (!seen && cyc < budget) begin
      tick(); cyc++;
      if (oe_o) oe_seen = 1'b1;
      if (done_o) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (run_det_o !== 1'b0) begin n_err++; $display("FAIL rst_run_det: got %b want 0", run_det_o); end
    n_cmp++; if (oe_o !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", oe_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
    n_cmp++; if (status_o !== 2'd0) begin n_err++; $display("FAIL rst_status: got %0d want 0", status_o); end
    n_cmp++; if (stb_cnt_o !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", stb_cnt_o); end
    arst_i = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int cyc; bit seen, oes; exp_t e;
    g_low = 40; g_period = 20; g_err = 1'b0; g_hold = 1'b0;
    sb.push_back(exp_t'{status: 2'd0, cnt: 16'd3});
    do_start(16'd3, 24'd1000);
    n_cmp++; if (run_det_o !== 1'b1) begin n_err++; $display("FAIL nom_run_det_c1: got %b want 1", run_det_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL nom_busy_c1: got %b want 1", busy_o); end
    tick();
    n_cmp++; if (run_det_o !== 1'b0) begin n_err++; $display("FAIL nom_run_det_c2: got %b want 0", run_det_o); end
    wait_done(500, cyc, seen, oes);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL nom_done: got no done want done"); end
    n_cmp++; if (cyc + 2 != 103) begin n_err++; $display("FAIL nom_done_cycle: got %0d want 103", cyc + 2); end
    n_cmp++; if (!oes) begin n_err++; $display("FAIL nom_oe_seen: got 0 want 1"); end
    n_cmp++; if (oe_o !== 1'b0) begin n_err++; $display("FAIL nom_oe_off: got %b want 0", oe_o); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL nom_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL nom_status: got %0d want %0d", status_o, e.status); end
      n_cmp++; if (stb_cnt_o !== e.cnt) begin n_err++; $display("FAIL nom_cnt: got %0d want %0d", stb_cnt_o, e.cnt); end
    end
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL nom_done_pulse: got %b want 0", done_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL nom_busy_end: got %b want 0", busy_o); end
  endtask

  task automatic test_det_err();
    int cyc; bit seen, oes; exp_t e;
    g_low = 10; g_err = 1'b1;
    sb.push_back(exp_t'{status: 2'd1, cnt: 16'd0});
    do_start(16'd3, 24'd1000);
    wait_done(200, cyc, seen, oes);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL det_done: got no done want done"); end
    n_cmp++; if (cyc + 1 != 13) begin n_err++; $display("FAIL det_done_cycle: got %0d want 13", cyc + 1); end
    n_cmp++; if (oes) begin n_err++; $display("FAIL det_oe: got oe high want never"); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL det_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL det_status: got %0d want %0d", status_o, e.status); end
      n_cmp++; if (stb_cnt_o !== e.cnt) begin n_err++; $display("FAIL det_cnt: got %0d want %0d", stb_cnt_o, e.cnt); end
    end
    g_err = 1'b0;
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL det_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_timeout();
    int cyc; bit seen, oes; exp_t e;
    g_hold = 1'b1;
    sb.push_back(exp_t'{status: 2'd2, cnt: 16'd0});
    do_start(16'd3, 24'd50);
    wait_done(200, cyc, seen, oes);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL to_done: got no done want done"); end
    n_cmp++; if (cyc + 1 != 52) begin n_err++; $display("FAIL to_done_cycle: got %0d want 52", cyc + 1); end
    n_cmp++; if (oes) begin n_err++; $display("FAIL to_oe: got oe high want never"); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL to_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL to_status: got %0d want %0d", status_o, e.status); end
      n_cmp++; if (stb_cnt_o !== e.cnt) begin n_err++; $display("FAIL to_cnt: got %0d want %0d", stb_cnt_o, e.cnt); end
    end
    tick();
    // timeout=0 disables expiry: still waiting after 10000 cycles
    do_start(16'd3, 24'd0);
    wait_done(10000, cyc, seen, oes);
    n_cmp++; if (seen) begin n_err++; $display("FAIL to0_no_done: got done at %0d want none", cyc + 1); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL to0_busy: got %b want 1", busy_o); end
    sb.push_back(exp_t'{status: 2'd3, cnt: 16'd0});
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL to0_abort_done: got %b want 1", done_o); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL to0_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL to0_status: got %0d want %0d", status_o, e.status); end
    end
    g_hold = 1'b0;
    tick();
  endtask

  task automatic test_abort_run();
    int k; exp_t e;
    g_low = 10; g_period = 20;
    sb.push_back(exp_t'{status: 2'd3, cnt: 16'd2});
    do_start(16'd5, 24'd1000);
    k = 0;
    while (stb_cnt_o != 16'd2 && k < 300) begin tick(); k++; end
    n_cmp++; if (stb_cnt_o !== 16'd2) begin n_err++; $display("FAIL ab_reach2: got %0d want 2", stb_cnt_o); end
    tick(); tick(); tick();
    // a start request while running must be ignored
    n_stb_i = 16'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n_cmp++; if (oe_o !== 1'b1) begin n_err++; $display("FAIL ab_start_ign_oe: got %b want 1", oe_o); end
    n_cmp++; if (stb_cnt_o !== 16'd2) begin n_err++; $display("FAIL ab_start_ign_cnt: got %0d want 2", stb_cnt_o); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (oe_o !== 1'b0) begin n_err++; $display("FAIL ab_oe_off: got %b want 0", oe_o); end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL ab_done: got %b want 1", done_o); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL ab_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL ab_status: got %0d want %0d", status_o, e.status); end
      n_cmp++; if (stb_cnt_o !== e.cnt) begin n_err++; $display("FAIL ab_cnt: got %0d want %0d", stb_cnt_o, e.cnt); end
    end
    tick();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL ab_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_edge();
    int cyc, k; bit seen, oes; exp_t e;
    // n = 0: completes OK without ever enabling the output
    g_low = 10; g_err = 1'b0;
    sb.push_back(exp_t'{status: 2'd0, cnt: 16'd0});
    do_start(16'd0, 24'd1000);
    wait_done(200, cyc, seen, oes);
    n_cmp++; if (!seen) begin n_err++; $display("FAIL n0_done: got no done want done"); end
    n_cmp++; if (oes) begin n_err++; $display("FAIL n0_oe: got oe high want never"); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL n0_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL n0_status: got %0d want %0d", status_o, e.status); end
    end
    tick();
    // abort and detection error in the same cycle: abort wins
    g_err = 1'b1;
    sb.push_back(exp_t'{status: 2'd3, cnt: 16'd0});
    do_start(16'd3, 24'd1000);
    k = 0;
    do begin @(negedge clk_i); #1; k++; end while (!(rdy_i && err_i) && k < 100);
    n_cmp++; if (!(rdy_i && err_i)) begin n_err++; $display("FAIL ae_err_seen: got rdy=%b err=%b want 1/1", rdy_i, err_i); end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL ae_done: got %b want 1", done_o); end
    if (sb.size() == 0) begin n_cmp++; n_err++; $display("FAIL ae_sb: got empty queue want entry"); end
    else begin
      e = sb.pop_front();
      n_cmp++; if (status_o !== e.status) begin n_err++; $display("FAIL ae_status: got %0d want %0d", status_o, e.status); end
    end
    g_err = 1'b0;
    tick();
    // async reset in RUN: outputs clear immediately, no completion pulse
    do_start(16'd5, 24'd1000);
    k = 0;
    while (stb_cnt_o != 16'd1 && k < 200) begin tick(); k++; end
    n_cmp++; if (oe_o !== 1'b1) begin n_err++; $display("FAIL rr_oe_before: got %b want 1", oe_o); end
    @(negedge clk_i); #1;
    arst_i = 1'b1;
    #1;
    n_cmp++; if (oe_o !== 1'b0) begin n_err++; $display("FAIL rr_oe: got %b want 0", oe_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rr_busy: got %b want 0", busy_o); end
    n_cmp++; if (status_o !== 2'd0) begin n_err++; $display("FAIL rr_status: got %0d want 0", status_o); end
    n_cmp++; if (stb_cnt_o !== '0) begin n_err++; $display("FAIL rr_cnt: got %0d want 0", stb_cnt_o); end
    n_cmp++; if (run_det_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL rr_pulses: got run_det=%b done=%b want 0/0", run_det_o, done_o); end
    tick();
    arst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (done_o) seen = 1'b1; end
    n_cmp++; if (seen) begin n_err++; $display("FAIL rr_no_done: got done pulse want none"); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_det_err();
    test_timeout();
    test_abort_run();
    test_edge();
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
